// File: rtl/j1_irq_controller_pkg.sv
// j1_irq_controller_pkg: register offsets, claim layout and priority helper for the J1 interrupt controller
package j1_irq_controller_pkg;
  localparam logic [15:0] IRQ_BASE_DEFAULT = 16'h0200;
  localparam logic [2:0] IRQ_PEND = 3'd0;
  localparam logic [2:0] IRQ_ENA = 3'd2;
  localparam logic [2:0] IRQ_MODE = 3'd4;
  localparam logic [2:0] IRQ_CLAIM = 3'd6;
  localparam int IRQ_CLAIM_VALID = 15;
  function automatic logic [4:0] claim_of(input logic [15:0] v);
    claim_of = '0;
    for (int i = 15; i >= 0; i--)
      if (v[i]) claim_of = {1'b1, i[3:0]};
  endfunction
endpackage

// File: rtl/j1_irq_controller_sync.sv
// irq_sync: 3-flop synchroniser for one asynchronous source, with a rising-edge strobe
module irq_sync (
  input  logic clk,
  input  logic resetq,
  input  logic d,
  output logic q,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) {s3, s2, s1} <= '0;
    else {s3, s2, s1} <= {s2, s1, d};
  assign q = s2;
  assign rise = s2 & ~s3;
endmodule

// File: rtl/j1_irq_controller.sv
// j1_irq_controller: multi-source edge/level interrupt controller on the J1 IO bus
module j1_irq_controller
  import j1_irq_controller_pkg::*;
#(
  parameter int NSRC = 8,
  parameter logic [15:0] BASE = IRQ_BASE_DEFAULT
) (
  input  logic            clk,
  input  logic            resetq,
  input  logic [NSRC-1:0] irq_src,
  input  logic            io_rd,
  input  logic            io_wr,
  input  logic [15:0]     io_addr,
  input  logic [15:0]     io_dout,
  output logic [15:0]     io_rdata,
  output logic            interrupt_request
);
  logic [1:0] rst_sync;
  logic rst_n;
  logic [NSRC-1:0] lvl, rise, pend, ena, mode, mode_n, clr;
  logic [15:0] pe;
  logic [4:0] claim;
  logic [2:0] off;
  logic hit, wr_pend, wr_ena, wr_mode, rd_claim;
  logic unused_ok;
  // reset asserts asynchronously but releases on a clock edge
  always_ff @(posedge clk or negedge resetq)
    if (!resetq) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_n = rst_sync[1];
  genvar i;
  for (i = 0; i < NSRC; i++) begin : g_sync
    irq_sync u_sync (.clk(clk), .resetq(rst_n), .d(irq_src[i]), .q(lvl[i]), .rise(rise[i]));
  end
  assign hit = io_addr[15:3] == BASE[15:3];
  assign off = {io_addr[2:1], 1'b0};
  assign wr_pend = hit & io_wr & (off == IRQ_PEND);
  assign wr_ena = hit & io_wr & (off == IRQ_ENA);
  assign wr_mode = hit & io_wr & (off == IRQ_MODE);
  assign rd_claim = hit & io_rd & (off == IRQ_CLAIM);
  assign pe = 16'(pend & ena);
  assign claim = claim_of(pe);
  assign unused_ok = ^{io_addr[0], io_dout};
  always_comb begin
    mode_n = wr_mode ? io_dout[NSRC-1:0] : mode;
    clr = (wr_pend ? io_dout[NSRC-1:0] : '0) | ((rd_claim && claim[4]) ? NSRC'(1) << claim[3:0] : '0);
    io_rdata = !hit ? '0 :
               off == IRQ_PEND ? 16'(pend) :
               off == IRQ_ENA ? 16'(ena) :
               off == IRQ_MODE ? 16'(mode) :
               (16'(claim[4]) << IRQ_CLAIM_VALID) | 16'(claim[3:0]);
  end
  // a new edge beats a simultaneous clear; bits entering edge mode start from the edge strobe only
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend <= '0;
      ena <= '0;
      mode <= '0;
      interrupt_request <= 1'b0;
    end else begin
      if (wr_ena) ena <= io_dout[NSRC-1:0];
      mode <= mode_n;
      pend <= (mode_n & (rise | (pend & mode & ~clr))) | (~mode_n & lvl);
      interrupt_request <= |(pend & ena);
    end
endmodule

// File: tb/tb_j1_irq_controller.sv
// tb_j1_irq_controller: directed and randomized checks of j1_irq_controller against a behavioural model
module tb_j1_irq_controller;
  localparam logic [15:0] P = 16'h0200, E = 16'h0202, M = 16'h0204, C = 16'h0206;
  logic clk = 0, resetq = 0, io_rd = 0, io_wr = 0;
  logic [7:0] irq_src = '0;
  logic [15:0] io_addr = P, io_dout = '0, io_rdata, pre;
  logic interrupt_request;
  int vectors = 0, miscompares = 0;
  bit [7:0] m_pend, m_ena, m_mode, src_v;
  bit m_req;
  bit [7:0] hist[$];

  j1_irq_controller dut (
    .clk(clk), .resetq(resetq), .irq_src(irq_src), .io_rd(io_rd), .io_wr(io_wr),
    .io_addr(io_addr), .io_dout(io_dout), .io_rdata(io_rdata), .interrupt_request(interrupt_request)
  );

  always #5 clk = ~clk;

  function automatic bit [15:0] m_claim();
    for (int i = 0; i < 8; i++)
      if (m_pend[i] && m_ena[i]) return 16'h8000 | 16'(i);
    return 16'h0000;
  endfunction

  function automatic bit [15:0] m_read(input bit [15:0] a);
    if (a[15:3] != 13'h0040) return 16'h0000;
    case (a[2:1])
      2'd0: return {8'h00, m_pend};
      2'd1: return {8'h00, m_ena};
      2'd2: return {8'h00, m_mode};
      default: return m_claim();
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_ena = '0;
    m_mode = '0;
    m_req = 0;
    hist = '{8'h00, 8'h00, 8'h00, 8'h00};
  endtask

  // hist[k] is the source vector sampled k+1 edges ago
  task automatic model_edge();
    bit [7:0] lvl, rise, clr, nm, np;
    bit [15:0] c;
    bit hit;
    bit [1:0] off;
    lvl = hist[1];
    rise = hist[1] & ~hist[2];
    hit = io_addr[15:3] == 13'h0040;
    off = io_addr[2:1];
    c = m_claim();
    clr = '0;
    if (hit && io_wr && off == 2'd0) clr |= io_dout[7:0];
    if (hit && io_rd && off == 2'd3 && c[15]) clr[c[2:0]] = 1'b1;
    nm = (hit && io_wr && off == 2'd2) ? io_dout[7:0] : m_mode;
    for (int i = 0; i < 8; i++)
      np[i] = nm[i] ? (rise[i] | (m_pend[i] & m_mode[i] & ~clr[i])) : lvl[i];
    m_req = |(m_pend & m_ena);
    if (hit && io_wr && off == 2'd1) m_ena = io_dout[7:0];
    m_mode = nm;
    m_pend = np;
    hist.push_front(irq_src);
    if (hist.size() > 4) void'(hist.pop_back());
  endtask

  task automatic cyc(input bit rd, input bit wr, input bit [15:0] addr, input bit [15:0] dout, input bit [7:0] src);
    io_rd = rd;
    io_wr = wr;
    io_addr = addr;
    io_dout = dout;
    irq_src = src;
    #1;
    pre = io_rdata;
    chk("rdata_pre", io_rdata, m_read(addr));
    @(posedge clk);
    model_edge();
    #1;
    chk("request", {15'h0, interrupt_request}, {15'h0, m_req});
    chk("rdata_post", io_rdata, m_read(addr));
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, P, 16'h0, 8'h00);
  endtask

  task automatic wr(input bit [15:0] a, input bit [15:0] d);
    cyc(0, 1, a, d, 8'h00);
  endtask

  task automatic do_reset();
    resetq = 0;
    io_rd = 0;
    io_wr = 0;
    irq_src = '0;
    io_addr = P;
    repeat (2) @(posedge clk);
    #2 resetq = 1;
    repeat (3) @(posedge clk);
    #1 model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();
    // reset state of every register
    cyc(0, 0, P, 0, 0); chk("rst_pend", pre, 16'h0000);
    cyc(0, 0, E, 0, 0); chk("rst_ena", pre, 16'h0000);
    cyc(0, 0, M, 0, 0); chk("rst_mode", pre, 16'h0000);
    cyc(0, 0, C, 0, 0); chk("rst_claim", pre, 16'h0000);
    chk("rst_req", {15'h0, interrupt_request}, 16'h0000);
    // single edge on source 2: exact latency, claim, clear
    wr(M, 16'h00FF);
    wr(E, 16'h0004);
    cyc(0, 0, P, 0, 8'h04); chk("t2_pend_k", io_rdata, 16'h0000);
    idle(1); chk("t2_pend_k1", io_rdata, 16'h0000);
    idle(1); chk("t2_pend_k2", io_rdata, 16'h0004); chk("t2_req_k2", {15'h0, interrupt_request}, 16'h0000);
    idle(1); chk("t2_req_k3", {15'h0, interrupt_request}, 16'h0001);
    cyc(1, 0, C, 0, 0); chk("t2_claim", pre, 16'h8002); chk("t2_req_claim", {15'h0, interrupt_request}, 16'h0001);
    idle(1); chk("t2_pend_clr", io_rdata, 16'h0000); chk("t2_req_low", {15'h0, interrupt_request}, 16'h0000);
    // two simultaneous edges claimed in priority order
    wr(E, 16'h00FF);
    cyc(0, 0, P, 0, 8'h22);
    idle(3); chk("t3_pend", io_rdata, 16'h0022);
    cyc(1, 0, C, 0, 0); chk("t3_claim1", pre, 16'h8001); chk("t3_req1", {15'h0, interrupt_request}, 16'h0001);
    cyc(1, 0, C, 0, 0); chk("t3_claim5", pre, 16'h8005); chk("t3_req2", {15'h0, interrupt_request}, 16'h0001);
    cyc(1, 0, C, 0, 0); chk("t3_claim_none", pre, 16'h0000); chk("t3_req3", {15'h0, interrupt_request}, 16'h0000);
    // level source 3 stays pending across claims
    wr(M, 16'h00F7);
    wr(E, 16'h0008);
    repeat (4) cyc(0, 0, P, 0, 8'h08);
    chk("t4_req", {15'h0, interrupt_request}, 16'h0001);
    repeat (3) begin
      cyc(1, 0, C, 0, 8'h08); chk("t4_claim", pre, 16'h8003);
    end
    cyc(0, 0, P, 0, 8'h08); chk("t4_pend_held", io_rdata, 16'h0008);
    idle(3); chk("t4_req_lag", {15'h0, interrupt_request}, 16'h0001);
    idle(1); chk("t4_req_off", {15'h0, interrupt_request}, 16'h0000);
    // new edge on source 0 collides with W1C of the same bit
    wr(M, 16'h00FF);
    wr(E, 16'h0001);
    cyc(0, 0, P, 0, 8'h01);
    idle(2); chk("t5_pend_set", io_rdata, 16'h0001);
    cyc(0, 0, P, 0, 8'h01);
    idle(1);
    cyc(0, 1, P, 16'h0001, 0); chk("t5_set_wins", io_rdata, 16'h0001);
    cyc(0, 1, P, 16'h0001, 0); chk("t5_w1c", io_rdata, 16'h0000);
    // masked edge latches; enabling raises request; reset drops it
    wr(E, 16'h0000);
    cyc(0, 0, P, 0, 8'h40);
    idle(3); chk("t6_pend", io_rdata, 16'h0040); chk("t6_masked", {15'h0, interrupt_request}, 16'h0000);
    wr(E, 16'h0040); chk("t6_req_wait", {15'h0, interrupt_request}, 16'h0000);
    idle(1); chk("t6_req_on", {15'h0, interrupt_request}, 16'h0001);
    #2 resetq = 0;
    #1;
    chk("t6_async_req", {15'h0, interrupt_request}, 16'h0000);
    chk("t6_async_pend", io_rdata, 16'h0000);
    do_reset();
    cyc(0, 0, E, 0, 0); chk("t6_ena_rst", pre, 16'h0000);
    // randomized traffic against the model
    src_v = '0;
    for (int n = 0; n < 500; n++) begin
      int r;
      bit [15:0] a;
      r = $urandom_range(0, 9);
      a = {13'h0040, 3'($urandom_range(0, 7))};
      if ($urandom_range(0, 15) == 0) a = 16'($urandom);
      if ($urandom_range(0, 2) == 0) src_v ^= 8'($urandom) & 8'($urandom);
      cyc(r < 3 || r == 9, (r >= 3 && r < 6) || r == 9, a, 16'($urandom), src_v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
